// File: rtl/sa_result_collector.sv
// Result collector behind the systolic-array deskew stage: buffers deskewed rows in a
// first-word-fall-through row FIFO and tracks per-tile row count, completion and overflow.
module sa_result_collector #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int ROW_W           = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               start,
  input  logic [ROW_W-1:0]                   num_rows,
  input  logic                               in_valid,
  input  logic [SA_SIZE*ACTIVATION_SIZE-1:0] in_row,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [SA_SIZE*ACTIVATION_SIZE-1:0] out_row,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow
);

  localparam int DW = SA_SIZE * ACTIVATION_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] num_rows_q, num_rows_d;
  logic [ROW_W-1:0] rows_in_q, rows_in_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [DW-1:0] mem_row  [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];

  logic start_acc, push, pop, full, wr_en, drop, last_tag;

  assign start_acc = (state_q == IDLE) && start;
  assign push      = (state_q == COLLECT) && in_valid;
  assign pop       = out_valid && out_ready;
  assign full      = (count_q == FULL_COUNT);
  // A full FIFO still takes the row when the head leaves in the same cycle.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign last_tag  = (rows_in_q == (num_rows_q - ROW_W'(1)));

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    rows_in_d  = rows_in_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          rows_in_d  = '0;
          overflow_d = 1'b0;
          state_d    = (num_rows != '0) ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          rows_in_d = rows_in_q + ROW_W'(1);
          if ((rows_in_q + ROW_W'(1)) == num_rows_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (drop) overflow_d = 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      rows_in_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      rows_in_q  <= rows_in_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the head outputs are masked until a row is present.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_row[wr_ptr_q]  <= in_row;
      mem_last[wr_ptr_q] <= last_tag;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_row   = out_valid ? mem_row[rd_ptr_q] : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr_q] : 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Scoreboard bench for sa_result_collector: directed tiles push expected rows into a queue,
// a negedge monitor compares every presented FIFO head against the queue front.
module tb_sa_result_collector;

  localparam int SA    = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int RW    = 16;
  localparam int DW    = SA * AW;

  typedef struct packed {
    logic [DW-1:0] row;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] numRows = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] inRow = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_row;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overflow;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass = 0;

  sa_result_collector #(
    .SA_SIZE(SA), .ACTIVATION_SIZE(AW), .FIFO_DEPTH(DEPTH), .ROW_W(RW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_rows(numRows),
    .in_valid(in_valid), .in_row(inRow),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Column c of row r in a tile is base + 0x10*r + c.
  function automatic logic [DW-1:0] makeRow(input int base, input int r);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < SA; c++) v[c*AW +: AW] = 32'(base + 16 * r + c);
    return v;
  endfunction

  // Monitor: whenever a head is presented it must equal the oldest expected row.
  always @(negedge clk) begin
    if (resetn && out_valid) begin
      if (expQ.size() == 0) begin
        nChecks++;
        $display("[TB] FAIL unexpectedRow: got %h expected no row", out_row);
      end else begin
        checkOutput("headRow", out_row, expQ[0].row);
        checkOutput("headLast", DW'(out_last), DW'(expQ[0].last));
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] row, input logic rdy);
    in_valid  = v;
    inRow     = row;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pushRow(input int base, input int r, input logic last, input logic keep, input logic rdy);
    exp_t e;
    e.row  = makeRow(base, r);
    e.last = last;
    if (keep) expQ.push_back(e);
    applyStimulus(1'b1, e.row, rdy);
  endtask

  task automatic startTile(input int n);
    start   = 1'b1;
    numRows = RW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(name, DW'(seen), DW'(1));
    if (seen) begin
      @(negedge clk);
      checkOutput({name, "Width"}, DW'(done), '0);
      checkOutput({name, "IdleAfter"}, DW'(busy), '0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    checkOutput("rstOutValid", DW'(out_valid), '0);
    checkOutput("rstOutLast", DW'(out_last), '0);
    checkOutput("rstOutRow", out_row, '0);
    checkOutput("rstBusy", DW'(busy), '0);
    checkOutput("rstDone", DW'(done), '0);
    checkOutput("rstOverflow", DW'(overflow), '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic 4-row tile with an always-ready consumer.
    startTile(4);
    checkOutput("t1Busy", DW'(busy), DW'(1));
    pushRow(0, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1Latency", DW'(out_valid), DW'(1));
    pushRow(0, 1, 1'b0, 1'b1, 1'b1);
    pushRow(0, 2, 1'b0, 1'b1, 1'b1);
    pushRow(0, 3, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    waitDone("t1Done", 20);
    checkOutput("t1Overflow", DW'(overflow), '0);

    // 20 rows into a 16-deep FIFO with a stalled consumer: rows 16..19 are lost.
    startTile(20);
    for (int r = 0; r < 20; r++) pushRow(32'h1000, r, 1'b0, r < DEPTH, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t2Overflow", DW'(overflow), DW'(1));
    checkOutput("t2Full", DW'(out_valid), DW'(1));
    checkOutput("t2DrainBusy", DW'(busy), DW'(1));
    out_ready = 1'b1;
    waitDone("t2Done", 40);
    checkOutput("t2OverflowSticky", DW'(overflow), DW'(1));

    // Full FIFO with simultaneous push and pop on the last two beats.
    startTile(18);
    checkOutput("t3OverflowCleared", DW'(overflow), '0);
    for (int r = 0; r < 18; r++) pushRow(32'h2000, r, r == 17, 1'b1, r >= DEPTH);
    applyStimulus(1'b0, '0, 1'b1);
    waitDone("t3Done", 40);
    checkOutput("t3Overflow", DW'(overflow), '0);

    // Consumer stalls mid-drain.
    startTile(4);
    for (int r = 0; r < 4; r++) pushRow(32'h3000, r, r == 3, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    out_ready = 1'b1;
    waitDone("t4Done", 20);

    // Empty tile, then input beats while idle.
    startTile(0);
    checkOutput("t5Busy", DW'(busy), DW'(1));
    checkOutput("t5Done", DW'(done), DW'(1));
    checkOutput("t5NoValid", DW'(out_valid), '0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5Idle", DW'(busy), '0);
    checkOutput("t5DoneLow", DW'(done), '0);
    applyStimulus(1'b1, makeRow(32'h4000, 0), 1'b1);
    applyStimulus(1'b1, makeRow(32'h4000, 1), 1'b1);
    checkOutput("t5IdleInputIgnored", DW'(out_valid), '0);
    applyStimulus(1'b0, '0, 1'b1);

    // A start during COLLECT must not relatch num_rows.
    startTile(3);
    pushRow(32'h5000, 0, 1'b0, 1'b1, 1'b1);
    start   = 1'b1;
    numRows = RW'(5);
    pushRow(32'h5000, 1, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    pushRow(32'h5000, 2, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    waitDone("t6Done", 20);

    // Asynchronous reset with three rows buffered.
    startTile(8);
    for (int r = 0; r < 3; r++) pushRow(32'h6000, r, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    #2;
    resetn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t7RstValid", DW'(out_valid), '0);
    checkOutput("t7RstBusy", DW'(busy), '0);
    checkOutput("t7RstOverflow", DW'(overflow), '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    startTile(2);
    pushRow(32'h7000, 0, 1'b0, 1'b1, 1'b1);
    pushRow(32'h7000, 1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    waitDone("t7Done", 20);

    checkOutput("queueEmpty", DW'(expQ.size()), '0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/sa_result_collector.md
Name: sa_result_collector

Overview:
- Sits directly downstream of the systolic-array output deskew stage.
- Captures each deskewed result row (SA_SIZE activations, all columns time-aligned) into a row FIFO.
- Hands rows to the result writer over a ready/valid interface and tracks per-tile row count, completion and overflow.
- The array cannot be stalled, so input is push-only; loss of rows is flagged, never back-pressured.

Parameters:
SA_SIZE, 8, number of columns (activations per row)
ACTIVATION_SIZE, 32, bits per activation
FIFO_DEPTH, 16, row FIFO depth in rows (power of two, >= 2)
ROW_W, 16, width of the row counters and num_rows

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  begin a tile; sampled only in IDLE
num_rows  input  ROW_W  rows expected in the tile, latched on accepted start
in_valid  input  1  deskewed row valid this cycle
in_row  input  [ACTIVATION_SIZE-1:0] x SA_SIZE  deskewed result row
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_row  output  [ACTIVATION_SIZE-1:0] x SA_SIZE  FIFO head row
out_last  output  1  head is row num_rows-1 of the tile
busy  output  1  FSM not IDLE
done  output  1  one-cycle pulse at tile completion
overflow  output  1  sticky; a row was dropped on a full FIFO

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; pointers, count and counters = 0.
  - out_valid=0, out_last=0, busy=0, done=0, overflow=0.
  - out_row = 0; FIFO storage need not be cleared.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: start with num_rows!=0 -> latch num_rows, clear rows_in, clear overflow -> COLLECT.
  - IDLE: start with num_rows==0 -> DONE (empty tile).
  - start outside IDLE is ignored.
  - COLLECT: each in_valid increments rows_in. The cycle rows_in+1 == num_rows -> DRAIN.
  - DRAIN: FIFO empty -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- busy = (state != IDLE), including DONE.
- Push: occurs when state==COLLECT and in_valid.
  - Stores in_row plus a last tag = (rows_in == num_rows-1).
  - in_valid in IDLE, DRAIN or DONE is ignored: no push, no count, no flag.
- Pop: occurs when out_valid && out_ready.
- FIFO is first-word-fall-through from registered storage:
  - A row pushed at edge N drives out_valid/out_row/out_last from cycle N+1.
  - Latency is 1 cycle with no bubble on back-to-back pushes.
- Full with simultaneous pop: push accepted, count unchanged.
- Full without pop:
  - Row dropped and overflow set.
  - rows_in still increments, so the tile always terminates after num_rows input beats.
  - A dropped last row means no out_last for that tile.
- Empty with simultaneous push: no pop (out_valid still 0 that cycle).
- out_valid = (count != 0). When out_valid=0, out_row and out_last are don't-care; the bench must not check them.
- out_row and out_last are held stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH, with full = (count==FIFO_DEPTH).
- overflow stays set through DONE and IDLE until the next accepted start or reset.
- Reset mid-tile: immediate return to reset state. FIFO contents are discarded (count=0).

Test Plan:
- Reset, then start with num_rows=4, 4 consecutive in_valid rows (col c = 0x10*row+c), out_ready=1 -> 4 rows out in order, one cycle after each push; out_last only on row 3; done pulses 1 cycle after the last pop; overflow=0.
- FIFO_DEPTH=16, num_rows=20, out_ready=0 for 20 pushes -> 16 rows stored; overflow=1; FSM reaches DRAIN. Then out_ready=1 -> rows 0..15 out, no out_last, done, overflow still 1 until the next start.
- Full FIFO with push and pop in the same cycle -> push accepted, no overflow, ordering preserved.
- out_ready toggled 1,0,0,1 during drain -> out_row/out_last stable while stalled; no row lost or duplicated.
- start with num_rows=0 -> busy=1 for 1 cycle, done pulse, no out_valid. Also: in_valid while IDLE -> ignored. start during COLLECT -> ignored.
- resetn deasserted asynchronously mid-COLLECT with 3 rows buffered -> out_valid=0, busy=0, overflow=0 immediately; the next tile behaves as after a fresh reset.
